// File: rtl/jstk_pkg.sv
// Shared types and constants for the joystick poll controller.
package jstk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_LOW,
      WAIT_HIGH,
      LATCH
   } state_e;

   // Upper six bits of the command byte; the two LED bits follow.
   localparam logic [5:0]  LED_CMD_PREFIX = 6'b100000;

   // Bit positions of the fields inside the 40-bit received word.
   localparam int X_LO_MSB = 39;
   localparam int X_HI_LSB = 24;
   localparam int Y_LO_MSB = 23;
   localparam int Y_HI_LSB = 8;
   localparam int BTN_LSB  = 0;

   localparam logic [9:0]  CENTRE    = 10'd512;
   localparam logic [39:0] CMD_RESET = {LED_CMD_PREFIX, 2'b00, 32'h0};

endpackage

// File: rtl/joystick_poll_ctrl_if.sv
// Handshake/data bundle between the poll controller and the SPI master.
interface joystick_poll_ctrl_if;

   logic        spi_trigger;
   logic [39:0] spi_out_bytes;
   logic [39:0] spi_in_bytes;
   logic        spi_cs;

   modport master (output spi_trigger, output spi_out_bytes,
                   input  spi_in_bytes, input spi_cs);
   modport slave  (input  spi_trigger, input spi_out_bytes,
                   output spi_in_bytes, output spi_cs);

endinterface

// File: rtl/jstk_poll_timer.sv
// Up-counter with clear and enable; saturates at CYCLES-1 and flags it.
module jstk_poll_timer #(
   parameter int CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expired
);

   localparam int            W    = $clog2(CYCLES);
   localparam logic [W-1:0]  LAST = W'(CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == LAST);

   // Next count: clear wins, otherwise count up and hold once expired.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && !expired)
         cnt_d = cnt_q + 1'b1;
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/joystick_poll_ctrl.sv
// Periodic 5-byte exchange sequencer for the joystick SPI master.
// Optional feature: define JSTK_AVG_EN to average each new X/Y sample
// with the previous raw sample.
module joystick_poll_ctrl
   import jstk_pkg::*;
#(
   parameter int POLL_CYCLES    = 1_000_000,
   parameter int TIMEOUT_CYCLES = 200_000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   led,
   joystick_poll_ctrl_if.master         spi,
   output logic [9:0]                   x_pos,
   output logic [9:0]                   y_pos,
   output logic [2:0]                   buttons,
   output logic                         sample_valid,
   output logic                         timeout_err
);

   state_e      state_q, state_d;
   logic        trig_q, trig_d;
   logic        valid_q, valid_d;
   logic        terr_q, terr_d;
   logic [39:0] cmd_q, cmd_d;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic [2:0]  btn_q, btn_d;

   logic poll_en, poll_clr, poll_exp;
   logic wait_en, wait_clr, wait_exp;

   logic [9:0] raw_x, raw_y, new_x, new_y;
   logic [2:0] raw_btn;

   // Field extraction from the received word.
   assign raw_x   = {spi.spi_in_bytes[X_HI_LSB +: 2], spi.spi_in_bytes[X_LO_MSB -: 8]};
   assign raw_y   = {spi.spi_in_bytes[Y_HI_LSB +: 2], spi.spi_in_bytes[Y_LO_MSB -: 8]};
   assign raw_btn = spi.spi_in_bytes[BTN_LSB +: 3];

   logic unused_in;
   assign unused_in = ^{spi.spi_in_bytes[31:26], spi.spi_in_bytes[15:10],
                        spi.spi_in_bytes[7:3]};

`ifdef JSTK_AVG_EN
   logic [9:0]  prev_x_q, prev_x_d, prev_y_q, prev_y_d;
   logic [10:0] sum_x, sum_y;

   assign sum_x = {1'b0, prev_x_q} + {1'b0, raw_x};
   assign sum_y = {1'b0, prev_y_q} + {1'b0, raw_y};
   assign new_x = sum_x[10:1];
   assign new_y = sum_y[10:1];
`else
   assign new_x = raw_x;
   assign new_y = raw_y;
`endif

   // The poll interval only runs while idle; the wait timer spans both cs waits.
   assign poll_en = (state_q == IDLE);
   assign wait_en = (state_q == WAIT_LOW) || (state_q == WAIT_HIGH);

   jstk_poll_timer #(.CYCLES(POLL_CYCLES)) u_poll_tmr (
      .clk(clk), .rst(rst), .en(poll_en), .clr(poll_clr), .expired(poll_exp)
   );

   jstk_poll_timer #(.CYCLES(TIMEOUT_CYCLES)) u_wait_tmr (
      .clk(clk), .rst(rst), .en(wait_en), .clr(wait_clr), .expired(wait_exp)
   );

   // Next-state and registered-output logic; outputs are loaded on the
   // transition so they appear in the cycle of the destination state.
   always_comb begin
      state_d  = state_q;
      trig_d   = 1'b0;
      valid_d  = 1'b0;
      terr_d   = terr_q;
      cmd_d    = cmd_q;
      x_d      = x_q;
      y_d      = y_q;
      btn_d    = btn_q;
      poll_clr = 1'b0;
      wait_clr = 1'b0;
`ifdef JSTK_AVG_EN
      prev_x_d = prev_x_q;
      prev_y_d = prev_y_q;
`endif
      case (state_q)
         IDLE: begin
            // A low cs at expiry means the master is still busy: hold.
            if (poll_exp && spi.spi_cs) begin
               state_d  = START;
               poll_clr = 1'b1;
               trig_d   = 1'b1;
               cmd_d    = {LED_CMD_PREFIX, led, 32'h0};
            end
         end
         START: begin
            state_d  = WAIT_LOW;
            wait_clr = 1'b1;
         end
         WAIT_LOW: begin
            if (!spi.spi_cs) begin
               state_d  = WAIT_HIGH;
               wait_clr = 1'b1;
            end else if (wait_exp) begin
               state_d = IDLE;
               terr_d  = 1'b1;
            end
         end
         WAIT_HIGH: begin
            // cs release takes priority over a same-cycle expiry.
            if (spi.spi_cs) begin
               state_d = LATCH;
               valid_d = 1'b1;
               x_d     = new_x;
               y_d     = new_y;
               btn_d   = raw_btn;
`ifdef JSTK_AVG_EN
               prev_x_d = raw_x;
               prev_y_d = raw_y;
`endif
            end else if (wait_exp) begin
               state_d = IDLE;
               terr_d  = 1'b1;
            end
         end
         LATCH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         trig_q  <= 1'b0;
         valid_q <= 1'b0;
         terr_q  <= 1'b0;
         cmd_q   <= CMD_RESET;
         x_q     <= CENTRE;
         y_q     <= CENTRE;
         btn_q   <= 3'b000;
`ifdef JSTK_AVG_EN
         prev_x_q <= CENTRE;
         prev_y_q <= CENTRE;
`endif
      end else begin
         state_q <= state_d;
         trig_q  <= trig_d;
         valid_q <= valid_d;
         terr_q  <= terr_d;
         cmd_q   <= cmd_d;
         x_q     <= x_d;
         y_q     <= y_d;
         btn_q   <= btn_d;
`ifdef JSTK_AVG_EN
         prev_x_q <= prev_x_d;
         prev_y_q <= prev_y_d;
`endif
      end
   end

   assign spi.spi_trigger   = trig_q;
   assign spi.spi_out_bytes = cmd_q;
   assign x_pos             = x_q;
   assign y_pos             = y_q;
   assign buttons           = btn_q;
   assign sample_valid      = valid_q;
   assign timeout_err       = terr_q;

endmodule

// File: tb/tb_joystick_poll_ctrl.sv
// Directed bench for joystick_poll_ctrl with a procedural SPI slave model.
module tb_joystick_poll_ctrl;

   localparam int POLL    = 100;
   localparam int TIMEOUT = 50;

   logic       clk;
   logic       rst;
   logic [1:0] led;
   logic [9:0] x_pos, y_pos;
   logic [2:0] buttons;
   logic       sample_valid, timeout_err;

   joystick_poll_ctrl_if sif ();

   joystick_poll_ctrl #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .led(led), .spi(sif.master),
      .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
      .sample_valid(sample_valid), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected-output model state (previous raw sample for averaging).
   logic [9:0] m_px = 10'd512;
   logic [9:0] m_py = 10'd512;
   logic [9:0] m_x  = 10'd512;
   logic [9:0] m_y  = 10'd512;
   logic [2:0] m_b  = 3'd0;

   typedef struct {
      logic [1:0]  led;
      logic [39:0] resp;
      int          low_len;
      logic [9:0]  rx;
      logic [9:0]  ry;
      logic [2:0]  rb;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until spi_trigger is seen; n = ticks taken (budget on expiry).
   task automatic wait_trigger(output int n);
      n = 0;
      while (n < 400) begin
         tick();
         n++;
         if (sif.spi_trigger) return;
      end
   endtask

   task automatic do_exchange(input string tag, input logic [1:0] l, input logic [39:0] resp,
                              input int low_len, input logic [9:0] rx, input logic [9:0] ry,
                              input logic [2:0] rb);
      logic [39:0] cmd;
      int n;
      led = l;
      cmd = {6'b100000, l, 32'h0};
      wait_trigger(n);
      check({tag, " trigger_wait"}, 64'(n), 64'(POLL));
      if (!sif.spi_trigger) return;
      check({tag, " cmd"}, 64'(sif.spi_out_bytes), 64'(cmd));
      sif.spi_in_bytes = resp;
      tick();
      check({tag, " trig_one_cycle"}, 64'(sif.spi_trigger), 64'd0);
      tick();
      sif.spi_cs = 1'b0;
      repeat (low_len) tick();
      sif.spi_cs = 1'b1;
      n = 0;
      while (n < 200) begin
         tick();
         n++;
         if (sample_valid) break;
      end
      check({tag, " valid_latency"}, 64'(n), 64'd1);
`ifdef JSTK_AVG_EN
      m_x  = 10'((11'(m_px) + 11'(rx)) >> 1);
      m_y  = 10'((11'(m_py) + 11'(ry)) >> 1);
      m_px = rx;
      m_py = ry;
`else
      m_x = rx;
      m_y = ry;
`endif
      m_b = rb;
      check({tag, " x_pos"}, 64'(x_pos), 64'(m_x));
      check({tag, " y_pos"}, 64'(y_pos), 64'(m_y));
      check({tag, " buttons"}, 64'(buttons), 64'(m_b));
      check({tag, " cmd_hold"}, 64'(sif.spi_out_bytes), 64'(cmd));
      tick();
      check({tag, " valid_pulse"}, 64'(sample_valid), 64'd0);
   endtask

   initial begin
      int n;
      int trig_seen;

      vecs[0] = '{2'b00, 40'hE8_03_00_00_00, 40, 10'h3E8, 10'h000, 3'd0};
      vecs[1] = '{2'b01, 40'h00_00_00_00_00, 10, 10'h000, 10'h000, 3'd0};
      vecs[2] = '{2'b11, 40'hA5_02_3C_01_05, 40, 10'h2A5, 10'h13C, 3'd5};
      vecs[3] = '{2'b10, 40'h12_FD_34_FE_F3,  3, 10'h112, 10'h234, 3'd3};

      rst = 1'b1;
      led = 2'b00;
      sif.spi_cs = 1'b1;
      sif.spi_in_bytes = 40'h0;
      repeat (3) tick();

      check("rst trigger", 64'(sif.spi_trigger), 64'd0);
      check("rst valid", 64'(sample_valid), 64'd0);
      check("rst timeout_err", 64'(timeout_err), 64'd0);
      check("rst out_bytes", 64'(sif.spi_out_bytes), 64'h80_0000_0000);
      check("rst x_pos", 64'(x_pos), 64'd512);
      check("rst y_pos", 64'(y_pos), 64'd512);
      check("rst buttons", 64'(buttons), 64'd0);
      rst = 1'b0;

      // First exchange: cs released one cycle before the wait timer would expire.
      do_exchange("near_timeout", 2'b00, 40'h00_02_00_02_06, TIMEOUT - 1,
                  10'd512, 10'd512, 3'd6);
      check("near_timeout err", 64'(timeout_err), 64'd0);

      // Slave never answers: error after TIMEOUT WAIT_LOW cycles, outputs untouched.
      wait_trigger(n);
      check("to trigger_wait", 64'(n), 64'(POLL));
      repeat (TIMEOUT) tick();
      check("to err_before", 64'(timeout_err), 64'd0);
      tick();
      check("to err_set", 64'(timeout_err), 64'd1);
      check("to x_pos", 64'(x_pos), 64'(m_x));
      check("to y_pos", 64'(y_pos), 64'(m_y));
      check("to buttons", 64'(buttons), 64'(m_b));

      for (int i = 0; i < 4; i++)
         do_exchange($sformatf("vec%0d", i), vecs[i].led, vecs[i].resp, vecs[i].low_len,
                     vecs[i].rx, vecs[i].ry, vecs[i].rb);
      check("err sticky", 64'(timeout_err), 64'd1);

      // Controller reset while the master holds cs low.
      led = 2'b00;
      wait_trigger(n);
      check("mid trigger_wait", 64'(n), 64'(POLL));
      tick();
      tick();
      sif.spi_cs = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_px = 10'd512;
      m_py = 10'd512;
      check("mid rst err", 64'(timeout_err), 64'd0);
      check("mid rst x_pos", 64'(x_pos), 64'd512);
      check("mid rst y_pos", 64'(y_pos), 64'd512);
      check("mid rst out_bytes", 64'(sif.spi_out_bytes), 64'h80_0000_0000);
      trig_seen = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (sif.spi_trigger) trig_seen++;
      end
      check("mid no_trigger_busy", 64'(trig_seen), 64'd0);
      sif.spi_cs = 1'b1;
      tick();
      check("mid trigger_after_cs", 64'(sif.spi_trigger), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/joystick_poll_ctrl.md
# joystick_poll_ctrl

Periodic transaction sequencer for the joystick SPI master (`spi`). It fires one 5-byte exchange every poll interval and drives the LED command byte. It watches the master's chip-select to detect start and end of each exchange, then decodes the returned bytes into X/Y position and button state for the game logic. It sits between the paddle-control logic and the `spi` instance, and is the only block that drives the master's `trigger` and `out_bytes`.

## Interface
- `POLL_CYCLES`, 1_000_000: clocks between exchange starts (10 ms at 100 MHz); must be ≥ 2.
- `TIMEOUT_CYCLES`, 200_000: maximum clocks allowed in each chip-select wait state.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `led` in 2: LED bits sent in command byte; sampled in START.
- `spi_trigger` out 1: one-cycle start pulse to the `spi` master.
- `spi_out_bytes` out 40: command word to the master.
- `spi_in_bytes` in 40: received word from the master; byte0 is in [39:32].
- `spi_cs` in 1: master's active-low chip-select, used as the busy indicator.
- `x_pos` out 10: joystick X, 0..1023.
- `y_pos` out 10: joystick Y, 0..1023.
- `buttons` out 3: {btn2, btn1, trigger_btn}.
- `sample_valid` out 1: one-cycle pulse when x/y/buttons update.
- `timeout_err` out 1: sticky; set on any timeout; cleared only by `rst`.

## Operation
- FSM states: IDLE, START, WAIT_LOW, WAIT_HIGH, LATCH.
- IDLE:
  - The poll counter increments each cycle.
  - When the counter reaches POLL_CYCLES-1 and `spi_cs`==1, the counter clears and the FSM goes to START.
  - If `spi_cs`==0 at expiry, the FSM stays in IDLE with the counter held until cs rises. This covers a master still busy after a controller-only reset.
- START:
  - `spi_out_bytes` ← {6'b100000, led, 32'h0}.
  - `spi_trigger`=1 for exactly this cycle.
  - Next state WAIT_LOW; wait counter cleared.
- WAIT_LOW:
  - On `spi_cs`==0, go to WAIT_HIGH and clear the wait counter.
  - On wait counter reaching TIMEOUT_CYCLES-1, set `timeout_err` and go to IDLE.
- WAIT_HIGH:
  - On `spi_cs`==1, go to LATCH.
  - On timeout, set `timeout_err` and go to IDLE; outputs are not updated.
- LATCH:
  - x_pos ← {in[25:24], in[39:32]}.
  - y_pos ← {in[9:8], in[23:16]}.
  - buttons ← in[2:0].
  - Pulse `sample_valid`, then go to IDLE.
- `spi_out_bytes` holds its value outside START.
- The poll counter runs only in IDLE, so the period is POLL_CYCLES plus the transfer length.
- Reset values:
  - State IDLE, both counters 0.
  - `spi_trigger`, `sample_valid`, `timeout_err` = 0.
  - `spi_out_bytes`=40'h80_0000_0000.
  - x_pos=y_pos=10'd512 (centre), buttons=0.
- Reset mid-transfer: the FSM returns to IDLE immediately. The `spi` master is not reset by this block; the IDLE cs-check guarantees no trigger is issued while it is busy.

## Timing
- The first START occurs POLL_CYCLES cycles after `rst` deasserts, given cs==1.
- `spi_trigger` is asserted in the cycle after the IDLE→START decision. `spi_out_bytes` is valid in that same cycle.
- The first WAIT_LOW cs check is the cycle after the trigger.
- Decoded outputs and `sample_valid` appear in the cycle after cs is first seen high in WAIT_HIGH (LATCH registers them).
- Exchange start to `sample_valid` is 3 + (cs-low duration) cycles.
- Outputs are registered, with no combinational path from `spi_in_bytes` to the outputs.
- `led` changes only take effect at the next START.

## Configuration
- `JSTK_AVG_EN` defined:
  - LATCH writes x_pos ← (prev_raw_x + new_x) >> 1, using an 11-bit sum truncated to 10 bits; the same applies to y_pos.
  - prev_raw_x/y are internal registers holding the last raw sample; they reset to 512.
  - buttons are not averaged.
- Not defined: raw values are written directly and the prev registers are not synthesized.

## Structure
- Package `jstk_pkg` holds:
  - state enum;
  - LED command prefix constant 6'b100000;
  - byte field offsets (X_LO_MSB=39, X_HI_LSB=24, Y_LO_MSB=23, Y_HI_LSB=8, BTN_LSB=0);
  - reset centre value 10'd512.
- Sub-module `jstk_poll_timer`:
  - Counter with enable, clear and `expired` output.
  - Instantiated twice: once as the poll counter (POLL_CYCLES), once as the wait/timeout counter (TIMEOUT_CYCLES).

## Test plan
- Reset, slave model with a 40-cycle cs-low window, POLL_CYCLES=100 → first `spi_trigger` at cycle 100 after reset; `spi_out_bytes`=40'h80_0000_0000 with led=0.
- led=2'b11; slave returns 40'hA5_02_3C_01_05 → `spi_out_bytes`[39:32]=8'h83; x_pos=10'h2A5, y_pos=10'h13C, buttons=3'b101; one `sample_valid` pulse.
- Slave never asserts cs, TIMEOUT_CYCLES=50 → `timeout_err`=1 after 50 WAIT_LOW cycles; x/y stay 512; polling resumes.
- Pulse `rst` during the cs-low window, with the slave holding cs low for 300 more cycles → no `spi_trigger` until cs=1, then the next trigger follows.
- With `JSTK_AVG_EN`, two samples with X=1000 then X=0 → x_pos=756 then 500.
- cs held low until 1 cycle before timeout, then released → no error; `sample_valid` pulses normally.
